// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MIPS memory stage: FSM state encoding,
// default cache geometry and byte-lane extract/merge helpers.
package mem_stage_pkg;

    localparam int DEFAULT_LINES = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        RESPOND   = 2'd3
    } mem_state_t;

    // Pick the addressed byte of a word and sign-extend it (lane 0 = bits 7:0).
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    // Replace the addressed byte of a word, leaving the other lanes intact.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [7:0]  b,
                                               input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // One-hot byte enable for a single lane.
    function automatic logic [3:0] lane_enable(input logic [1:0] lane);
        case (lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped data cache storage: per-line valid, dirty, tag and one data
// word. Combinational read port, synchronous byte-enabled write port.
// A write is either a refill (sets valid, clears dirty, loads the tag) or a
// store (sets dirty). Valid/dirty clear on the synchronous active-high reset.
module dcache_array
    import mem_stage_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             rd_dirty,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic             wr_fill,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data
);

    logic [LINES-1:0] valid_bits;
    logic [LINES-1:0] dirty_bits;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    // Combinational read of the indexed line.
    always_comb begin
        rd_valid = valid_bits[rd_idx];
        rd_dirty = dirty_bits[rd_idx];
        rd_tag   = tag_mem[rd_idx];
        rd_data  = data_mem[rd_idx];
    end

    // Line status bits: reset clears all, refill validates, store dirties.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (wr_en) begin
            if (wr_fill) begin
                valid_bits[wr_idx] <= 1'b1;
                dirty_bits[wr_idx] <= 1'b0;
            end else begin
                dirty_bits[wr_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage; no reset needed since valid gates their use.
    always_ff @(posedge clk) begin
        if (!rst_b && wr_en) begin
            if (wr_fill) begin
                tag_mem[wr_idx] <= wr_tag;
            end
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: services loads/stores from the EX/MEM buffer through
// a direct-mapped, write-back, write-allocate cache with one word per line.
// Misses stall the pipeline while the line is written back (if dirty) and
// refilled from a multi-cycle backing memory; the access completes in RESPOND.
// Optional hit/miss counters are built when MEM_ACCESS_PERF_EN is defined.
//
// Backing-memory handshake: mem_req (with mem_we/mem_addr/mem_wdata) is held
// steady until a single-cycle mem_ready pulse completes the transfer; for a
// read, mem_rdata is valid in the mem_ready cycle. mem_ready in any other
// state is ignored.
module mem_access_unit
    import mem_stage_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        req_is_word,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    mem_state_t state;
    mem_state_t next_state;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       req_lane;

    logic             line_valid;
    logic             line_dirty;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic             line_hit;

    logic             wr_en;
    logic             wr_fill;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    logic             access_hit;
    logic             miss_detect;

    assign req_idx  = req_addr[IDX_W+1:2];
    assign req_tag  = req_addr[31:IDX_W+2];
    assign req_lane = req_addr[1:0];
    assign line_hit = line_valid && (line_tag == req_tag);

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_dcache_array (
        .clk      (clk),
        .rst_b    (rst_b),
        .rd_idx   (req_idx),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_fill  (wr_fill),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_be    (wr_be),
        .wr_data  (wr_data)
    );

    // FSM state register; reset aborts any in-flight writeback/refill.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, memory interface, cache writes and load data.
    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        rdata       = 32'h0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        wr_en       = 1'b0;
        wr_fill     = 1'b0;
        wr_be       = 4'h0;
        wr_data     = 32'h0;
        access_hit  = 1'b0;
        miss_detect = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (line_hit) begin
                        access_hit = 1'b1;
                    end else begin
                        miss_detect = 1'b1;
                        stall       = 1'b1;
                        next_state  = (line_valid && line_dirty) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag, req_idx, 2'b00};
                mem_wdata = line_data;
                if (mem_ready) begin
                    next_state = REFILL;
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {req_addr[31:2], 2'b00};
                if (mem_ready) begin
                    wr_en      = 1'b1;
                    wr_fill    = 1'b1;
                    wr_be      = 4'hF;
                    wr_data    = mem_rdata;
                    next_state = RESPOND;
                end
            end
            RESPOND: begin
                // Line was filled on the previous edge, so this is a hit.
                access_hit = req_valid;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (access_hit) begin
            if (req_we) begin
                wr_en = 1'b1;
                if (req_is_word) begin
                    wr_be   = 4'hF;
                    wr_data = req_wdata;
                end else begin
                    wr_be   = lane_enable(req_lane);
                    wr_data = lane_merge(line_data, req_wdata[7:0], req_lane);
                end
            end else begin
                rdata = req_is_word ? line_data : lane_extract(line_data, req_lane);
            end
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    // Saturating hit counter: accesses served in IDLE without a miss.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            hit_count <= 32'h0;
        end else if (state == IDLE && access_hit && hit_count != 32'hFFFF_FFFF) begin
            hit_count <= hit_count + 32'd1;
        end
    end

    // Saturating miss counter: counted once, in the miss-detect cycle.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            miss_count <= 32'h0;
        end else if (miss_detect && miss_count != 32'hFFFF_FFFF) begin
            miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
